// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg: shared constants, capture-state encoding and frame decoder | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sseg_pkg;

    localparam logic [6:0] TOP_SQUARE    = 7'b0011100;
    localparam logic [6:0] BOTTOM_SQUARE = 7'b0100011;
    localparam logic [6:0] BLANK         = 7'b1111111;
    localparam int         PHASE_W       = 3;

    typedef enum logic [1:0] {
        CAP_IDLE     = 2'd0,
        CAP_SETTLING = 2'd1,
        CAP_HELD     = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic               valid;
        logic [PHASE_W-1:0] pos;
    } decode_t;

    // A frame is valid only with exactly one square and three blank digits.
    function automatic decode_t decode_frame(input logic [3:0][6:0] digs,
                                             input logic [6:0]      top,
                                             input logic [6:0]      bot);
        decode_t    r;
        logic [2:0] n_sq;
        logic [2:0] n_blank;
        r       = '0;
        n_sq    = '0;
        n_blank = '0;
        for (int k = 0; k < 4; k++) begin
            if (digs[k] == top) begin
                n_sq  = n_sq + 3'd1;
                r.pos = PHASE_W'(3 - k);
            end else if (digs[k] == bot) begin
                n_sq  = n_sq + 3'd1;
                r.pos = PHASE_W'(4 + k);
            end else if (digs[k] == BLANK) begin
                n_blank = n_blank + 3'd1;
            end
        end
        r.valid = (n_sq == 3'd1) && (n_blank == 3'd3);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_scan_capture.sv
// ---------------------------------------------------------------------------
// sseg_scan_capture: input stage, stability counter and capture FSM | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] an_i,
    input  logic [6:0] sseg_i,
    output logic       cap_o,
    output logic [1:0] idx_o,
    output logic [6:0] pat_o,
    output logic       multi_o
);

    // The change is seen one edge after the new sample lands, so the last
    // stable count is two below SETTLE.
    localparam logic [7:0] C_CNT_LAST = 8'(SETTLE - 2);

    logic [3:0] an_q;
    logic [6:0] sseg_q;
    logic [3:0] an_last_q;
    logic [6:0] sseg_last_q;
    logic [7:0] cnt_q;
    cap_state_e state_q;

    logic       w_change;
    logic [3:0] w_low;

    assign w_change = {an_q, sseg_q} != {an_last_q, sseg_last_q};
    assign w_low    = ~an_q;
    assign multi_o  = (w_low & (w_low - 4'd1)) != 4'd0;
    assign pat_o    = sseg_q;
    assign cap_o    = (state_q == CAP_SETTLING) && !w_change &&
                      (cnt_q == C_CNT_LAST) && !multi_o;

    always_comb begin
        idx_o = 2'd0;
        case (an_q)
            4'b1101: idx_o = 2'd1;
            4'b1011: idx_o = 2'd2;
            4'b0111: idx_o = 2'd3;
            default: idx_o = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_q        <= 4'hF;
            sseg_q      <= BLANK;
            an_last_q   <= 4'hF;
            sseg_last_q <= BLANK;
            cnt_q       <= '0;
            state_q     <= CAP_IDLE;
        end else begin
            an_q        <= an_i;
            sseg_q      <= sseg_i;
            an_last_q   <= an_q;
            sseg_last_q <= sseg_q;
            if (w_change) begin
                cnt_q   <= '0;
                state_q <= (an_q == 4'hF) ? CAP_IDLE : CAP_SETTLING;
            end else begin
                case (state_q)
                    CAP_SETTLING: begin
                        if (cnt_q == C_CNT_LAST) begin
                            state_q <= CAP_HELD;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_decoder.sv
// ---------------------------------------------------------------------------
// sseg_scan_decoder: frame assembly, square-phase decode and step check | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int         SETTLE        = 4,
    parameter logic [6:0] TOP_SQUARE    = sseg_pkg::TOP_SQUARE,
    parameter logic [6:0] BOTTOM_SQUARE = sseg_pkg::BOTTOM_SQUARE
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         an_i,
    input  logic [6:0]         sseg_i,
    output logic [6:0]         dig0_o,
    output logic [6:0]         dig1_o,
    output logic [6:0]         dig2_o,
    output logic [6:0]         dig3_o,
    output logic               frame_done_o,
    output logic               pos_valid_o,
    output logic [PHASE_W-1:0] pos_o,
    output logic               step_o,
    output logic [2:0]         err_o
);

    logic               w_cap;
    logic [1:0]         w_idx;
    logic [6:0]         w_pat;
    logic               w_multi;
    logic [3:0]         w_cap_mask;
    decode_t            w_dec;
    logic [PHASE_W-1:0] w_pos_next;

    logic [3:0][6:0]    dig_q;
    logic [3:0]         seen_q;
    logic               frame_done_q;
    logic               pos_valid_q;
    logic [PHASE_W-1:0] pos_q;
    logic               step_q;
    logic [2:0]         err_q;
    logic               hist_q;

    sseg_scan_capture #(
        .SETTLE (SETTLE)
    ) u_capture (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .an_i    (an_i),
        .sseg_i  (sseg_i),
        .cap_o   (w_cap),
        .idx_o   (w_idx),
        .pat_o   (w_pat),
        .multi_o (w_multi)
    );

    assign w_cap_mask = w_cap ? (4'b0001 << w_idx) : 4'b0000;
    assign w_dec      = decode_frame(dig_q, TOP_SQUARE, BOTTOM_SQUARE);
    assign w_pos_next = pos_q + PHASE_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dig_q        <= {4{BLANK}};
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            pos_valid_q  <= 1'b0;
            pos_q        <= '0;
            step_q       <= 1'b0;
            err_q        <= '0;
            hist_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            step_q       <= 1'b0;
            if (w_cap) begin
                dig_q[w_idx] <= w_pat;
            end
            if (w_multi) begin
                err_q[0] <= 1'b1;
            end
            // Decode sees the completed frame; a same-edge capture opens the next one.
            if (seen_q == 4'hF) begin
                frame_done_q <= 1'b1;
                seen_q       <= w_cap_mask;
                if (w_dec.valid) begin
                    pos_valid_q <= 1'b1;
                    pos_q       <= w_dec.pos;
                    hist_q      <= 1'b1;
                    if (hist_q && (w_dec.pos != pos_q)) begin
                        step_q <= 1'b1;
                        if (w_dec.pos != w_pos_next) begin
                            err_q[2] <= 1'b1;
                        end
                    end
                end else begin
                    pos_valid_q <= 1'b0;
                    err_q[1]    <= 1'b1;
                end
            end else begin
                seen_q <= seen_q | w_cap_mask;
            end
        end
    end

    assign dig0_o       = dig_q[0];
    assign dig1_o       = dig_q[1];
    assign dig2_o       = dig_q[2];
    assign dig3_o       = dig_q[3];
    assign frame_done_o = frame_done_q;
    assign pos_valid_o  = pos_valid_q;
    assign pos_o        = pos_q;
    assign step_o       = step_q;
    assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_decoder: scoreboard bench for the scanned 7-segment decoder | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sseg_scan_decoder;

    localparam int         SETTLE = 4;
    localparam logic [6:0] TOP    = 7'b0011100;
    localparam logic [6:0] BOT    = 7'b0100011;
    localparam logic [6:0] BLK    = 7'b1111111;

    typedef struct packed {
        logic       valid;
        logic [2:0] pos;
        logic       step;
        logic [2:0] err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an;
    logic [6:0] sseg;
    logic [6:0] dig0, dig1, dig2, dig3;
    logic       frame_done, pos_valid, step;
    logic [2:0] pos, err;

    res_t exp_q[$];
    res_t obs_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   fd_count = 0;
    int   step_count = 0;

    // Reference model state
    bit         m_hist;
    logic [2:0] m_pos;
    logic [2:0] m_err;

    always #5 clk = ~clk;

    sseg_scan_decoder #(
        .SETTLE        (SETTLE),
        .TOP_SQUARE    (TOP),
        .BOTTOM_SQUARE (BOT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .an_i         (an),
        .sseg_i       (sseg),
        .dig0_o       (dig0),
        .dig1_o       (dig1),
        .dig2_o       (dig2),
        .dig3_o       (dig3),
        .frame_done_o (frame_done),
        .pos_valid_o  (pos_valid),
        .pos_o        (pos),
        .step_o       (step),
        .err_o        (err)
    );

    function automatic logic [3:0][6:0] phase_frame(input int p);
        logic [3:0][6:0] d;
        d = {4{BLK}};
        if (p < 4) d[3-p] = TOP;
        else       d[p-4] = BOT;
        return d;
    endfunction

    task automatic push_expected(input logic [3:0][6:0] d);
        int   nsq;
        int   nblk;
        int   ph;
        res_t r;
        nsq = 0; nblk = 0; ph = 0;
        for (int k = 0; k < 4; k++) begin
            if (d[k] == TOP)      begin nsq++; ph = 3 - k; end
            else if (d[k] == BOT) begin nsq++; ph = 4 + k; end
            else if (d[k] == BLK) nblk++;
        end
        r = '0;
        if (nsq == 1 && nblk == 3) begin
            r.valid = 1'b1;
            if (m_hist && ph != int'(m_pos)) begin
                r.step = 1'b1;
                if (ph != ((int'(m_pos) + 1) % 8)) m_err[2] = 1'b1;
            end
            m_pos  = 3'(ph);
            m_hist = 1'b1;
        end else begin
            m_err[1] = 1'b1;
        end
        r.pos = m_pos;
        r.err = m_err;
        exp_q.push_back(r);
    endtask

    // One cycle of observation, sampled on the falling edge.
    task automatic sample();
        @(negedge clk);
        if (frame_done === 1'b1) begin
            obs_q.push_back(res_t'({pos_valid, pos, step, err}));
            fd_count++;
        end
        if (step === 1'b1) step_count++;
    endtask

    task automatic hold(input int n);
        repeat (n) sample();
    endtask

    task automatic drive_frame(input logic [3:0][6:0] d);
        push_expected(d);
        for (int k = 0; k < 4; k++) begin
            an   = ~(4'b0001 << k);
            sseg = d[k];
            hold(SETTLE + 2);
        end
        an   = 4'hF;
        sseg = BLK;
        hold(4);
    endtask

    task automatic assert_reset();
        rst  = 1'b1;
        an   = 4'hF;
        sseg = BLK;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        rst    = 1'b0;
        m_hist = 1'b0;
        m_pos  = '0;
        m_err  = '0;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        assert_reset();
        n_cmp++;
        if ({dig3, dig2, dig1, dig0} !== {4{BLK}}) begin
            n_fail++;
            $display("FAIL reset_digits: got %h required %h", {dig3, dig2, dig1, dig0}, {4{BLK}});
        end
        n_cmp++;
        if ({frame_done, pos_valid, step} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b required 000", {frame_done, pos_valid, step});
        end
        n_cmp++;
        if (pos !== 3'd0) begin n_fail++; $display("FAIL reset_pos: got %0d required 0", pos); end
        n_cmp++;
        if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b required 000", err); end
        release_reset();
    endtask

    task automatic test_single_frame();
        int   base;
        res_t e, o;
        base = fd_count;
        drive_frame(phase_frame(0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL single_frame: no frame_done_o, required %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL single_frame: got %b required %b", o, e); end
            end
        end
        n_cmp++;
        if (fd_count - base != 1) begin
            n_fail++; $display("FAIL single_frame_pulses: got %0d required 1", fd_count - base);
        end
        n_cmp++;
        if ({dig3, dig2} !== {TOP, BLK}) begin
            n_fail++; $display("FAIL single_frame_digits: got %b %b required %b %b", dig3, dig2, TOP, BLK);
        end
        n_cmp++;
        if ({pos_valid, pos} !== 4'b1000) begin
            n_fail++; $display("FAIL single_frame_pos: got %b required 1000", {pos_valid, pos});
        end
    endtask

    task automatic test_phase_sweep();
        int   base;
        res_t e, o;
        assert_reset();
        release_reset();
        base = step_count;
        for (int p = 0; p < 9; p++) drive_frame(phase_frame(p % 8));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL sweep_frame: no frame_done_o, required %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL sweep_frame: got %b required %b", o, e); end
            end
        end
        n_cmp++;
        if (step_count - base != 8) begin
            n_fail++; $display("FAIL sweep_steps: got %0d required 8", step_count - base);
        end
        n_cmp++;
        if (err !== 3'b000) begin n_fail++; $display("FAIL sweep_err: got %b required 000", err); end
    endtask

    task automatic test_out_of_order();
        res_t e, o;
        assert_reset();
        release_reset();
        drive_frame(phase_frame(2));
        drive_frame(phase_frame(4));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL order_frame: no frame_done_o, required %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL order_frame: got %b required %b", o, e); end
            end
        end
        n_cmp++;
        if ({pos, err[2]} !== {3'd4, 1'b1}) begin
            n_fail++; $display("FAIL order_err: got pos %0d err2 %b required pos 4 err2 1", pos, err[2]);
        end
    endtask

    task automatic test_glitch_multi();
        int base;
        assert_reset();
        release_reset();
        base = fd_count;
        an = 4'b1110; sseg = TOP; hold(SETTLE - 1);
        an = 4'hF;    sseg = BLK; hold(4);
        n_cmp++;
        if (dig0 !== BLK) begin n_fail++; $display("FAIL glitch_short: got %b required %b", dig0, BLK); end
        an = 4'b1101; sseg = BOT; hold(SETTLE);
        an = 4'hF;    sseg = BLK; hold(3);
        n_cmp++;
        if (dig1 !== BOT) begin n_fail++; $display("FAIL glitch_exact: got %b required %b", dig1, BOT); end
        an = 4'b1100; sseg = 7'h00; hold(SETTLE + 2);
        an = 4'hF;    sseg = BLK;   hold(3);
        n_cmp++;
        if (err !== 3'b001) begin n_fail++; $display("FAIL multi_err: got %b required 001", err); end
        n_cmp++;
        if ({dig1, dig0} !== {BOT, BLK} || fd_count != base) begin
            n_fail++; $display("FAIL multi_nocap: got %b %b frames %0d required %b %b frames 0",
                               dig1, dig0, fd_count - base, BOT, BLK);
        end
    endtask

    task automatic test_bad_frame();
        res_t            e, o;
        logic [3:0][6:0] d;
        assert_reset();
        release_reset();
        drive_frame(phase_frame(3));
        d = {TOP, TOP, BLK, BLK};
        drive_frame(d);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL bad_frame: no frame_done_o, required %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL bad_frame: got %b required %b", o, e); end
            end
        end
        n_cmp++;
        if ({pos_valid, pos, err[1]} !== {1'b0, 3'd3, 1'b1}) begin
            n_fail++; $display("FAIL bad_frame_hold: got valid %b pos %0d err1 %b required 0 3 1",
                               pos_valid, pos, err[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   base;
        res_t e, o;
        drive_frame(phase_frame(5));
        an = 4'b1110; sseg = BLK; hold(SETTLE + 2);
        an = 4'b1101; sseg = BLK; hold(SETTLE + 2);
        assert_reset();
        n_cmp++;
        if ({dig3, dig2, dig1, dig0} !== {4{BLK}}) begin
            n_fail++; $display("FAIL midreset_digits: got %h required %h", {dig3, dig2, dig1, dig0}, {4{BLK}});
        end
        n_cmp++;
        if ({frame_done, pos_valid, step, pos, err} !== 9'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b required 0", {frame_done, pos_valid, step, pos, err});
        end
        release_reset();
        base = fd_count;
        drive_frame(phase_frame(0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL midreset_frame: no frame_done_o, required %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL midreset_frame: got %b required %b", o, e); end
            end
        end
        n_cmp++;
        if (fd_count - base != 1) begin
            n_fail++; $display("FAIL midreset_pulses: got %0d required 1", fd_count - base);
        end
    endtask

    initial begin
        rst  = 1'b1;
        an   = 4'hF;
        sseg = BLK;
        m_hist = 1'b0;
        m_pos  = '0;
        m_err  = '0;
        test_reset();
        test_single_frame();
        test_phase_sweep();
        test_out_of_order();
        test_glitch_multi();
        test_bad_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4, giving the consecutive identical sampled cycles needed before a digit is captured (legal range 2..255).
REQ-002 SHALL have parameter TOP_SQUARE, default 7'b0011100, the active-low top-square pattern (segments a,b,f,g lit; sseg bit order {g,f,e,d,c,b,a}).
REQ-003 SHALL have parameter BOTTOM_SQUARE, default 7'b0100011, the active-low bottom-square pattern (segments c,d,e,g lit).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port an_i, input, 4 bits: scanned anode enables, active-low, bit k selects digit k.
REQ-007 SHALL have port sseg_i, input, 7 bits: scanned segment lines, active-low.
REQ-008 SHALL have ports dig0_o, dig1_o, dig2_o and dig3_o, output, 7 bits each: the last captured pattern of digits 0 to 3.
REQ-009 SHALL have port frame_done_o, output, 1 bit: one-cycle pulse when all four digits have been captured since the last frame.
REQ-010 SHALL have port pos_valid_o, output, 1 bit: the last frame decoded to exactly one square.
REQ-011 SHALL have port pos_o, output, 3 bits: the decoded square phase.
REQ-012 SHALL have port step_o, output, 1 bit: one-cycle pulse when a valid pos_o changes value.
REQ-013 SHALL have port err_o, output, 3 bits, sticky: bit0 multiple anodes low, bit1 bad frame pattern, bit2 out-of-order step.

Function
REQ-014 SHALL register an_i and sseg_i through one input stage; all logic SHALL use only the registered values.
REQ-015 Capture FSM SHALL have states IDLE (registered an all-high), SETTLING (counting), HELD (already captured, waiting for a change).
REQ-016 Any change of the registered {an,sseg} SHALL clear the stability counter and enter SETTLING, or IDLE if an is all-high.
REQ-017 With an_i/sseg_i applied before edge E0 and held, the matching dig<k>_o SHALL update on edge E0+SETTLE, seen[k] SHALL set, and the FSM SHALL enter HELD.
REQ-018 SHALL capture at most once per stable period; HELD SHALL make no further writes until the inputs change.
REQ-019 A registered an with more than one bit low SHALL set err_o[0] and SHALL cause no capture.
REQ-020 The edge after seen reaches 4'b1111, frame_done_o SHALL pulse and seen SHALL clear; a capture on that same edge SHALL leave its own seen bit set.
REQ-021 On the frame_done_o edge, if exactly one digit equals TOP_SQUARE or BOTTOM_SQUARE and the other three equal 7'b1111111, pos_valid_o SHALL be 1 and pos_o SHALL be loaded with the phase.
REQ-022 Phase encoding SHALL be: top on digit 3, 2, 1, 0 gives 0, 1, 2, 3; bottom on digit 0, 1, 2, 3 gives 4, 5, 6, 7.
REQ-023 Any other frame content SHALL clear pos_valid_o, hold pos_o, and set err_o[1].
REQ-024 On a valid frame whose pos differs from the previous valid pos, step_o SHALL pulse with pos_o; if new is not (prev+1) mod 8, err_o[2] SHALL set.
REQ-025 The wrap from 7 to 0 SHALL be a legal step; the first valid frame after reset SHALL not pulse step_o or check order.
REQ-026 A repeated identical valid frame SHALL produce no step_o.

Reset
REQ-027 On rst_i, SHALL force: dig*_o to 7'b1111111; frame_done_o, step_o and pos_valid_o to 0; pos_o to 0; err_o to 0; seen, counter and history cleared; FSM in IDLE.
REQ-028 A reset asserted mid-settle or mid-frame SHALL discard the partial frame; capture SHALL restart only with inputs presented after reset release.

Structure
REQ-029 Package sseg_pkg SHALL hold the TOP_SQUARE, BOTTOM_SQUARE and BLANK constants, the capture-state enum and the phase width.
REQ-030 Sub-module sseg_scan_capture SHALL contain the input stage, stability counter and capture FSM, emitting a digit index, pattern and capture strobe; the top level SHALL hold the frame, decode and step logic.

Verification
REQ-031 Scan each an_i in turn (1110, 1101, 1011, 0111), each held SETTLE+2 cycles, with digit 3 = 0011100 and others blank -> frame_done_o one pulse, pos_valid_o=1, pos_o=0.
REQ-032 Frames for phases 0 through 7 then 0 -> eight step_o pulses, err_o=3'b000 (wrap accepted).
REQ-033 Phase 2 then phase 4 -> step_o pulse, pos_o=4, err_o[2]=1.
REQ-034 Glitch holding a slot for SETTLE-1 cycles -> no dig change; an_i=4'b1100 -> err_o[0]=1, no capture.
REQ-035 Frame with two digits = 0011100 -> pos_valid_o=0, pos_o unchanged, err_o[1]=1.
REQ-036 rst_i asserted after two digits of a frame -> all outputs at reset values; the next full scan yields one frame_done_o.
